jesd204_tx_frame_char_insert: RTL and testbench
===============================================

// Module: jesd204_tx_frame_char_insert
// PURPOSE
//  TX-lane counterpart of the RX frame-alignment character replacement: tracks frame and multiframe
//  position of the outgoing octet stream and replaces end-of-frame octets with /F/ (K28.7, 8'hFC)
//  and end-of-multiframe octets with /A/ (K28.3, 8'h7C), per JESD204B user-data rules. Sits per lane
//  between scrambler and 8b/10b encoder; emits charisk for the encoder.
// PARAMETERS
//  DATA_PATH_WIDTH  4  octets per beat (4 or 8); octet 0 is first on the wire (LSB-first)
// PORTS
//  clk                           in   1        lane clock
//  reset                         in   1        async, active-high
//  cfg_octets_per_frame          in   8        F-1
//  cfg_octets_per_multiframe     in   10       F*K-1; F*K must be a multiple of DATA_PATH_WIDTH
//  cfg_disable_char_replacement  in   1        1: pass data through, charisk all 0
//  cfg_disable_scrambler         in   1        1: equality rule; 0: fixed-value rule
//  in_start                      in   1        with in_valid: this beat starts multiframe 0
//  in_valid                      in   1        beat qualifier
//  in_data                       in   8*DPW    octets
//  out_valid                     out  1        in_valid delayed 1 cycle
//  out_data                      out  8*DPW    octets after replacement
//  out_charisk                   out  DPW      1 where octet replaced by /A/ or /F/
//  out_eof / out_eomf            out  DPW each position markers, aligned with out_data
// BEHAVIOUR
//  Reset: all outputs 0; octet position counters 0; prev_last=8'h00; prev_replaced=1; armed=0.
//  Latency: exactly 1 cycle from in_* to out_*, all outputs registered; no backpressure.
//  Position: octet counters advance by DPW per valid beat only; frame counter wraps at
//   cfg_octets_per_frame, multiframe counter at cfg_octets_per_multiframe. in_start forces
//   position 0 for octet 0 of that beat and sets armed=1; in_start without in_valid is ignored.
//  Per octet i: eof[i] = frame position == F-1; eomf[i] = multiframe position == F*K-1
//   (eomf implies eof). Frame boundaries may fall mid-beat (e.g. F=3, DPW=4).
//  Before first in_start (armed=0): data passes, charisk 0, markers 0.
//  Scrambler disabled: at eof octet, replace if octet == prev_last AND prev_replaced==0;
//   character is /A/ if eomf else /F/. prev_last <= original (pre-replacement) octet;
//   prev_replaced <= replaced flag. Chain evaluated in octet order within a beat (a beat may hold
//   several eof octets; each compares against the preceding one in the same beat). First frame
//   after in_start never replaced (prev_replaced=1 on start).
//  Scrambler enabled: eomf octet == 8'h7C -> charisk=1 (value unchanged); non-eomf eof octet
//   == 8'hFC -> charisk=1. No history used.
//  cfg_disable_char_replacement=1: no replacement, charisk 0, markers still generated.
//  Config changes are only legal while in_valid=0 followed by in_start.
//  Invalid beats: out_valid=0, out_charisk=0, history and counters hold.
//  Reset mid-operation: all state to reset values; output resumes only after next in_start.
// STRUCTURE
//  Shared package jesd204_pkg: K28_3 (8'h7C), K28_7 (8'hFC) constants.
//  One sub-module: jesd204_tx_frame_pos_counter (frame/multiframe octet counters -> eof/eomf per octet),
//  reusable by the RX lane. Top holds the per-octet replacement chain and output registers.
// TESTING
//  1 F=1,K=32,DPW=4, scr off, const data 8'h55 after start -> octets 0..2 data, 3 /F/? no: octet 0 kept,
//    octet1 /F/ (charisk), octet2 8'h55 kept, octet3 /F/; every 32nd octet /A/ 8'h7C.
//  2 F=2,K=16, scr off, incrementing data (no repeats) -> charisk never set; eof every 2nd octet,
//    eomf at octet 31 of each multiframe.
//  3 F=3,DPW=4, scr off, data 8'hAA -> eof at octets 2,5,8..; replaced alternately (2 kept,5 /F/,8 kept).
//  4 scr on, F=4,K=8: inject 8'hFC at octet 3 -> charisk=1 data 8'hFC; 8'h7C at octet 31 -> charisk=1;
//    8'hFC at octet 31 -> charisk=0.
//  5 cfg_disable_char_replacement=1 with data of test 1 -> out_data==in_data, charisk 0, 1-cycle latency.
//  6 assert reset mid-stream -> next cycle all outputs 0; no output activity until new in_start,
//    then first frame not replaced; in_valid gaps hold counters (compare vs gap-free model).

Source files
------------

// File: rtl/jesd204_pkg.sv
// Shared JESD204 lane definitions: control-character codes used by the TX and RX
// frame-alignment logic.
package jesd204_pkg;

   // K28.3 is the /A/ character that marks the last octet of a multiframe
   localparam logic [7:0] K28_3 = 8'h7C;
   // K28.7 is the /F/ character that marks the last octet of a frame
   localparam logic [7:0] K28_7 = 8'hFC;

endpackage

// File: rtl/jesd204_tx_frame_pos_counter.sv
// Frame and multiframe octet position tracker for one lane. For the current beat it
// reports, per octet, whether that octet closes a frame (eof) or a multiframe (eomf).
// The eof/eomf outputs are combinational; the caller decides whether to register them.
// A qualified start forces octet 0 of the beat to position 0 in both counters.
module jesd204_tx_frame_pos_counter #(
   parameter int DPW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [7:0]     i_cfg_octets_per_frame,
   input  logic [9:0]     i_cfg_octets_per_multiframe,
   input  logic           i_valid,
   input  logic           i_start,
   output logic [DPW-1:0] o_eof,
   output logic [DPW-1:0] o_eomf
);

   logic [7:0]            r_frame_pos;
   logic [9:0]            r_mf_pos;
   logic [DPW-1:0][7:0]   w_frame_pos;
   logic [DPW-1:0][9:0]   w_mf_pos;
   logic [7:0]            w_frame_next;
   logic [9:0]            w_mf_next;

   // Walk the octets of the beat in wire order, wrapping each counter at its last
   // position, so a frame boundary can land anywhere inside the beat.
   always_comb begin
      w_frame_pos    = '0;
      w_mf_pos       = '0;
      o_eof          = '0;
      o_eomf         = '0;
      w_frame_pos[0] = i_start ? 8'd0  : r_frame_pos;
      w_mf_pos[0]    = i_start ? 10'd0 : r_mf_pos;
      for (int i = 1; i < DPW; i++) begin
         w_frame_pos[i] = (w_frame_pos[i-1] == i_cfg_octets_per_frame) ? 8'd0
                          : w_frame_pos[i-1] + 8'd1;
         w_mf_pos[i]    = (w_mf_pos[i-1] == i_cfg_octets_per_multiframe) ? 10'd0
                          : w_mf_pos[i-1] + 10'd1;
      end
      w_frame_next = (w_frame_pos[DPW-1] == i_cfg_octets_per_frame) ? 8'd0
                     : w_frame_pos[DPW-1] + 8'd1;
      w_mf_next    = (w_mf_pos[DPW-1] == i_cfg_octets_per_multiframe) ? 10'd0
                     : w_mf_pos[DPW-1] + 10'd1;
      for (int i = 0; i < DPW; i++) begin
         o_eomf[i] = (w_mf_pos[i] == i_cfg_octets_per_multiframe);
         o_eof[i]  = (w_frame_pos[i] == i_cfg_octets_per_frame) | o_eomf[i];
      end
   end

   // Counters only move on valid beats so gaps in the stream do not shift alignment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_pos <= 8'd0;
         r_mf_pos    <= 10'd0;
      end else if (i_valid) begin
         r_frame_pos <= w_frame_next;
         r_mf_pos    <= w_mf_next;
      end
   end

endmodule

// File: rtl/jesd204_tx_frame_char_insert.sv
// TX lane frame-alignment character insertion. Sits between the scrambler and the
// 8b/10b encoder: replaces end-of-frame octets with /F/ and end-of-multiframe octets
// with /A/ (unscrambled lanes), or flags naturally occurring control values
// (scrambled lanes), and hands the encoder a charisk bit per octet.
module jesd204_tx_frame_char_insert
   import jesd204_pkg::*;
#(
   parameter int DATA_PATH_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   cfg_octets_per_frame,
   input  logic [9:0]                   cfg_octets_per_multiframe,
   input  logic                         cfg_disable_char_replacement,
   input  logic                         cfg_disable_scrambler,
   input  logic                         in_start,
   input  logic                         in_valid,
   input  logic [8*DATA_PATH_WIDTH-1:0] in_data,
   output logic                         out_valid,
   output logic [8*DATA_PATH_WIDTH-1:0] out_data,
   output logic [DATA_PATH_WIDTH-1:0]   out_charisk,
   output logic [DATA_PATH_WIDTH-1:0]   out_eof,
   output logic [DATA_PATH_WIDTH-1:0]   out_eomf
);

   localparam int DPW = DATA_PATH_WIDTH;

   logic                 r_armed;
   logic [7:0]           r_prev_last;
   logic                 r_prev_replaced;

   logic                 w_start;
   logic                 w_armed;
   logic [DPW-1:0]       w_eof;
   logic [DPW-1:0]       w_eomf;
   logic [8*DPW-1:0]     w_data;
   logic [DPW-1:0]       w_charisk;
   logic [7:0]           w_prev_last;
   logic                 w_prev_replaced;
   logic [7:0]           w_octet;
   logic                 w_replace;

   assign w_start = in_start & in_valid;
   assign w_armed = r_armed | w_start;

   jesd204_tx_frame_pos_counter #(
      .DPW (DPW)
   ) u_pos_counter (
      .clk                         (clk),
      .reset                       (reset),
      .i_cfg_octets_per_frame      (cfg_octets_per_frame),
      .i_cfg_octets_per_multiframe (cfg_octets_per_multiframe),
      .i_valid                     (in_valid),
      .i_start                     (w_start),
      .o_eof                       (w_eof),
      .o_eomf                      (w_eomf)
   );

   // Per-octet replacement chain in wire order. Each end-of-frame octet is compared
   // with the previous end-of-frame octet (possibly earlier in the same beat), and a
   // replaced octet blocks replacement of the next one. The history carries the
   // original octet, not the inserted control character.
   always_comb begin
      w_data          = in_data;
      w_charisk       = '0;
      w_prev_last     = r_prev_last;
      w_prev_replaced = w_start ? 1'b1 : r_prev_replaced;
      w_octet         = 8'h00;
      w_replace       = 1'b0;
      for (int i = 0; i < DPW; i++) begin
         w_octet   = in_data[8*i +: 8];
         w_replace = 1'b0;
         if (w_armed && !cfg_disable_char_replacement) begin
            if (cfg_disable_scrambler) begin
               if (w_eof[i]) begin
                  w_replace       = (w_octet == w_prev_last) && !w_prev_replaced;
                  w_prev_last     = w_octet;
                  w_prev_replaced = w_replace;
                  if (w_replace) begin
                     w_data[8*i +: 8] = w_eomf[i] ? K28_3 : K28_7;
                     w_charisk[i]     = 1'b1;
                  end
               end
            end else begin
               if (w_eomf[i]) begin
                  w_charisk[i] = (w_octet == K28_3);
               end else if (w_eof[i]) begin
                  w_charisk[i] = (w_octet == K28_7);
               end
            end
         end
      end
   end

   // Output and history registers: one cycle of latency, outputs quiet on idle beats,
   // and replacement history frozen until the next valid beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_charisk     <= '0;
         out_eof         <= '0;
         out_eomf        <= '0;
         r_armed         <= 1'b0;
         r_prev_last     <= 8'h00;
         r_prev_replaced <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data        <= w_data;
            out_charisk     <= w_charisk;
            out_eof         <= w_armed ? w_eof  : '0;
            out_eomf        <= w_armed ? w_eomf : '0;
            r_armed         <= w_armed;
            r_prev_last     <= w_prev_last;
            r_prev_replaced <= w_prev_replaced;
         end else begin
            out_data    <= '0;
            out_charisk <= '0;
            out_eof     <= '0;
            out_eomf    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_jesd204_tx_frame_char_insert.sv
// Bench for the TX frame-character inserter (4 octets per beat). Stimulus beats push
// their expected output into a queue from an octet-indexed reference model; a monitor
// on the falling edge pops and compares whenever the DUT presents a valid beat.
module tb_jesd204_tx_frame_char_insert;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  charisk;
      logic [3:0]  eof;
      logic [3:0]  eomf;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [7:0]  cfgF;
   logic [9:0]  cfgFk;
   logic        cfgDisRepl;
   logic        cfgDisScr;
   logic        inStart;
   logic        inValid;
   logic [31:0] inData;
   logic        outValid;
   logic [31:0] outData;
   logic [3:0]  outCharisk;
   logic [3:0]  outEof;
   logic [3:0]  outEomf;

   exp_t        expQ[$];
   int          checks;
   int          failures;

   bit          mArmed;
   int          mIdx;
   logic [7:0]  mPrevLast;
   bit          mPrevRep;

   jesd204_tx_frame_char_insert #(
      .DATA_PATH_WIDTH (4)
   ) dut (
      .clk                          (clk),
      .reset                        (reset),
      .cfg_octets_per_frame         (cfgF),
      .cfg_octets_per_multiframe    (cfgFk),
      .cfg_disable_char_replacement (cfgDisRepl),
      .cfg_disable_scrambler        (cfgDisScr),
      .in_start                     (inStart),
      .in_valid                     (inValid),
      .in_data                      (inData),
      .out_valid                    (outValid),
      .out_data                     (outData),
      .out_charisk                  (outCharisk),
      .out_eof                      (outEof),
      .out_eomf                     (outEomf)
   );

   // Free-running lane clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model for one valid beat, working from the absolute octet index since
   // the last start; result goes to the back of the expectation queue.
   task automatic modelBeat(input bit start, input logic [31:0] d);
      exp_t       e;
      int         f;
      int         fk;
      bit         isEof;
      bit         isEomf;
      bit         rep;
      logic [7:0] oct;
      f  = int'(cfgF) + 1;
      fk = int'(cfgFk) + 1;
      e  = '0;
      if (start) begin
         mArmed   = 1'b1;
         mIdx     = 0;
         mPrevRep = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         oct = d[8*i +: 8];
         if (mArmed) begin
            isEomf    = (mIdx % fk) == fk - 1;
            isEof     = ((mIdx % f) == f - 1) || isEomf;
            e.eof[i]  = isEof;
            e.eomf[i] = isEomf;
            if (!cfgDisRepl) begin
               if (cfgDisScr) begin
                  if (isEof) begin
                     rep       = (oct == mPrevLast) && !mPrevRep;
                     mPrevLast = oct;
                     mPrevRep  = rep;
                     if (rep) begin
                        e.charisk[i] = 1'b1;
                        oct          = isEomf ? 8'h7C : 8'hFC;
                     end
                  end
               end else begin
                  e.charisk[i] = isEomf ? (oct == 8'h7C) : (isEof && oct == 8'hFC);
               end
            end
            mIdx++;
         end
         e.data[8*i +: 8] = oct;
      end
      expQ.push_back(e);
   endtask

   // Drive one beat on the falling edge and record what it should produce
   task automatic applyStimulus(input bit start, input bit valid, input logic [31:0] d);
      @(negedge clk);
      inStart = start;
      inValid = valid;
      inData  = d;
      if (valid) modelBeat(start, d);
   endtask

   // Compare one observed beat against the front of the expectation queue
   task automatic checkOutput();
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL unexpected_beat got data=%h charisk=%b, required no valid beat",
                  outData, outCharisk);
      end else begin
         e = expQ.pop_front();
         if (outData !== e.data || outCharisk !== e.charisk ||
             outEof !== e.eof || outEomf !== e.eomf) begin
            failures++;
            $display("[TB] FAIL beat got data=%h k=%b eof=%b eomf=%b, required data=%h k=%b eof=%b eomf=%b",
                     outData, outCharisk, outEof, outEomf, e.data, e.charisk, e.eof, e.eomf);
         end
      end
   endtask

   // Monitor: valid beats are scored against the queue; idle beats must carry no charisk
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (outValid === 1'b1) begin
               checkOutput();
            end else begin
               checks++;
               if (outCharisk !== 4'b0000 || outValid !== 1'b0) begin
                  failures++;
                  $display("[TB] FAIL idle_beat got valid=%b charisk=%b, required valid=0 charisk=0000",
                           outValid, outCharisk);
               end
            end
         end
      end
   end

   // All outputs must be zero while reset has just been applied
   task automatic checkResetOutputs(input string name);
      checks++;
      if (outValid !== 1'b0 || outData !== 32'h0 || outCharisk !== 4'h0 ||
          outEof !== 4'h0 || outEomf !== 4'h0) begin
         failures++;
         $display("[TB] FAIL %s got valid=%b data=%h k=%b eof=%b eomf=%b, required all zero",
                  name, outValid, outData, outCharisk, outEof, outEomf);
      end
   endtask

   // Reset the model alongside the DUT
   task automatic modelReset();
      mArmed    = 1'b0;
      mIdx      = 0;
      mPrevLast = 8'h00;
      mPrevRep  = 1'b1;
   endtask

   // Change lane configuration during an idle beat, ahead of the next start
   task automatic setConfig(input int f, input int fk, input bit disRepl, input bit disScr);
      applyStimulus(1'b0, 1'b0, 32'h0);
      cfgF       = 8'(f - 1);
      cfgFk      = 10'(fk - 1);
      cfgDisRepl = disRepl;
      cfgDisScr  = disScr;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      inStart    = 1'b0;
      inValid    = 1'b0;
      inData     = 32'h0;
      cfgF       = 8'd0;
      cfgFk      = 10'd31;
      cfgDisRepl = 1'b0;
      cfgDisScr  = 1'b1;
      modelReset();
      repeat (3) @(posedge clk);
      #2;
      checkResetOutputs("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // Before any start: data passes untouched with no markers
      applyStimulus(1'b0, 1'b1, 32'h55555555);
      applyStimulus(1'b0, 1'b1, 32'hFCFCFCFC);

      // F=1, K=32, unscrambled constant data: every second octet becomes /F/, octet 31 /A/
      setConfig(1, 32, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h55555555);
      for (int b = 1; b < 18; b++) applyStimulus(1'b0, 1'b1, 32'h55555555);

      // F=2, K=16, incrementing data never repeats so nothing is replaced
      setConfig(2, 32, 1'b0, 1'b1);
      for (int b = 0; b < 10; b++)
         applyStimulus(b == 0, 1'b1, {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)});

      // F=3, K=4: frame ends fall mid-beat, replacement alternates on constant data
      setConfig(3, 12, 1'b0, 1'b1);
      for (int b = 0; b < 7; b++) applyStimulus(b == 0, 1'b1, 32'hAAAAAAAA);

      // Scrambled lane, F=4, K=8: natural /F/ and /A/ values are flagged, not rewritten
      setConfig(4, 32, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hFC112233);
      applyStimulus(1'b0, 1'b1, 32'h7C000000);
      for (int b = 2; b < 7; b++) applyStimulus(1'b0, 1'b1, 32'h01020304);
      applyStimulus(1'b0, 1'b1, 32'h7C000000);
      for (int b = 8; b < 15; b++) applyStimulus(1'b0, 1'b1, 32'hFC0000FC);
      applyStimulus(1'b0, 1'b1, 32'hFC000000);

      // Replacement disabled: data passes, markers still reported
      setConfig(1, 32, 1'b1, 1'b1);
      for (int b = 0; b < 10; b++) applyStimulus(b == 0, 1'b1, 32'h55555555);

      // Mid-stream reset, then restart with gaps in the valid stream
      setConfig(1, 32, 1'b0, 1'b1);
      for (int b = 0; b < 4; b++) applyStimulus(b == 0, 1'b1, 32'h55555555);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkResetOutputs("mid_stream_reset");
      modelReset();
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL pending_before_reset got %0d queued beats, required 0", expQ.size());
         expQ.delete();
      end
      @(negedge clk);
      reset = 1'b0;
      for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h55555555);
      for (int b = 1; b < 20; b++) begin
         applyStimulus(1'b0, 1'b1, 32'h55555555);
         if (b % 3 == 0) applyStimulus(1'b0, 1'b0, 32'h12345678);
      end

      // Drain and confirm every expected beat was seen
      for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b0, 32'h0);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain got %0d unseen beats, required 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
